// File: rtl/pm_min_search_pipe.sv
// Pipelined min/max path-metric search: a registered comparator tree reduces LANES metrics
// per beat, and an accumulator folds the beats of one trellis step into a single winner.
module pm_min_search_pipe #(
    parameter int unsigned SM_W       = 8,
    parameter int unsigned LANES      = 32,
    parameter int unsigned NUM_STATES = 64,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned SEL_MAX    = 0,
    parameter int unsigned REV_IDX    = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_last_i,
    input  logic [LANES*SM_W-1:0] in_pm_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [SM_W-1:0]       out_pm_o,
    output logic [IDX_W-1:0]      out_idx_o,
    output logic                  err_seq_o
);
    localparam int unsigned LEVELS = $clog2(LANES);
    localparam int unsigned TOP    = LEVELS - 1;
    localparam int unsigned BEATS  = NUM_STATES / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

    // Modular compare: true when a beats b. Callers keep the lower raw index in b.
    function automatic logic beats(input logic [SM_W-1:0] a, input logic [SM_W-1:0] b);
        logic [SM_W-1:0] diff;
        logic            res;
        diff = a - b;
        if (SEL_MAX != 0) begin
            res = ~diff[SM_W-1] & (a != b);
        end else begin
            res = diff[SM_W-1];
        end
        return res;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [SM_W-1:0]  out_pm_q, out_pm_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stall, accept, cnt_at_max, step_close;

    assign stall      = out_valid_q & ~out_ready_i;
    assign in_ready_o = ~stall;
    assign accept     = in_valid_i & ~stall;
    assign cnt_at_max = (cnt_q == CNT_MAX);
    // A full count without in_last closes the step just as in_last would.
    assign step_close = in_last_i | cnt_at_max;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = step_close ? '0 : cnt_q + 1'b1;
            if (in_last_i != cnt_at_max) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    genvar l, j;
    generate
        for (l = 0; l < LEVELS; l++) begin : g_lvl
            localparam int unsigned NOUT = LANES >> (l + 1);
            logic [SM_W-1:0]  in_val [2*NOUT];
            logic [IDX_W-1:0] in_idx [2*NOUT];
            logic             in_vld, in_first, in_last;
            logic [SM_W-1:0]  val_q [NOUT];
            logic [IDX_W-1:0] idx_q [NOUT];
            logic             vld_q, first_q, last_q;

            if (l == 0) begin : g_src
                for (j = 0; j < 2 * NOUT; j++) begin : g_lane
                    assign in_val[j] = in_pm_i[j*SM_W +: SM_W];
                    assign in_idx[j] = IDX_W'(32'(cnt_q) * LANES + j);
                end
                assign in_vld   = accept;
                assign in_first = (cnt_q == '0);
                assign in_last  = step_close;
            end else begin : g_src
                for (j = 0; j < 2 * NOUT; j++) begin : g_lane
                    assign in_val[j] = g_lvl[l-1].val_q[j];
                    assign in_idx[j] = g_lvl[l-1].idx_q[j];
                end
                assign in_vld   = g_lvl[l-1].vld_q;
                assign in_first = g_lvl[l-1].first_q;
                assign in_last  = g_lvl[l-1].last_q;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q   <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    for (int unsigned k = 0; k < NOUT; k++) begin
                        val_q[k] <= '0;
                        idx_q[k] <= '0;
                    end
                end else if (!stall) begin
                    vld_q   <= in_vld;
                    first_q <= in_first;
                    last_q  <= in_last;
                    for (int unsigned k = 0; k < NOUT; k++) begin
                        if (beats(in_val[2*k+1], in_val[2*k])) begin
                            val_q[k] <= in_val[2*k+1];
                            idx_q[k] <= in_idx[2*k+1];
                        end else begin
                            val_q[k] <= in_val[2*k];
                            idx_q[k] <= in_idx[2*k];
                        end
                    end
                end
            end
        end
    endgenerate

    logic [SM_W-1:0]  t_val, acc_val_q, acc_val_d, win_val;
    logic [IDX_W-1:0] t_idx, acc_idx_q, acc_idx_d, win_idx;
    logic             t_vld, t_first, t_last;

    assign t_val   = g_lvl[TOP].val_q[0];
    assign t_idx   = g_lvl[TOP].idx_q[0];
    assign t_vld   = g_lvl[TOP].vld_q;
    assign t_first = g_lvl[TOP].first_q;
    assign t_last  = g_lvl[TOP].last_q;

    always_comb begin
        win_val = t_val;
        win_idx = t_idx;
        if (!t_first && !beats(t_val, acc_val_q)) begin
            win_val = acc_val_q;
            win_idx = acc_idx_q;
        end
        acc_val_d   = acc_val_q;
        acc_idx_d   = acc_idx_q;
        out_valid_d = out_valid_q & ~out_ready_i;
        out_pm_d    = out_pm_q;
        out_idx_d   = out_idx_q;
        if (t_vld && !stall) begin
            acc_val_d = win_val;
            acc_idx_d = win_idx;
            if (t_last) begin
                out_valid_d = 1'b1;
                out_pm_d    = win_val;
                out_idx_d   = (REV_IDX != 0) ? IDX_W'(NUM_STATES - 1) - win_idx : win_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_val_q   <= '0;
            acc_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_pm_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            acc_val_q   <= acc_val_d;
            acc_idx_q   <= acc_idx_d;
            out_valid_q <= out_valid_d;
            out_pm_q    <= out_pm_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_pm_o    = out_pm_q;
    assign out_idx_o   = out_idx_q;
    assign err_seq_o   = err_q;

endmodule

// File: tb/tb_pm_min_search_pipe.sv
// Scoreboard bench: three parameter variants (min/rev, min/raw, max/rev) share one stimulus
// stream; expected winners are hand-derived per vector and checked by a separate monitor.
module tb_pm_min_search_pipe;
    localparam int unsigned SM_W       = 8;
    localparam int unsigned LANES      = 32;
    localparam int unsigned NUM_STATES = 64;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned ND         = 3;
    localparam int          LAT        = 6;

    logic                  clk = 1'b0;
    logic                  rst, in_valid, in_last, out_ready;
    logic [LANES*SM_W-1:0] in_pm;
    logic                  in_ready  [ND];
    logic                  out_valid [ND];
    logic                  err_seq   [ND];
    logic [SM_W-1:0]       out_pm    [ND];
    logic [IDX_W-1:0]      out_idx   [ND];

    typedef struct packed {
        logic [ND-1:0][SM_W-1:0]  pm;
        logic [ND-1:0][IDX_W-1:0] idx;
    } exp_t;

    exp_t            q[$];
    logic [SM_W-1:0] vec [NUM_STATES];
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    pm_min_search_pipe #(.SEL_MAX(0), .REV_IDX(1)) u_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_last_i(in_last), .in_pm_i(in_pm), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready), .out_pm_o(out_pm[0]), .out_idx_o(out_idx[0]),
        .err_seq_o(err_seq[0])
    );
    pm_min_search_pipe #(.SEL_MAX(0), .REV_IDX(0)) u_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_last_i(in_last), .in_pm_i(in_pm), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready), .out_pm_o(out_pm[1]), .out_idx_o(out_idx[1]),
        .err_seq_o(err_seq[1])
    );
    pm_min_search_pipe #(.SEL_MAX(1), .REV_IDX(1)) u_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
        .in_last_i(in_last), .in_pm_i(in_pm), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready), .out_pm_o(out_pm[2]), .out_idx_o(out_idx[2]),
        .err_seq_o(err_seq[2])
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int base, input int r1, input int v1, input int r2,
                           input int v2);
        for (int i = 0; i < NUM_STATES; i++) vec[i] = SM_W'(base);
        if (r1 >= 0) vec[r1] = SM_W'(v1);
        if (r2 >= 0) vec[r2] = SM_W'(v2);
    endtask

    // Expected winners given as raw indices; each variant maps them its own way.
    task automatic push_exp(input int min_pm, input int min_raw, input int max_pm,
                            input int max_raw);
        exp_t e;
        e.pm[0]  = SM_W'(min_pm);
        e.idx[0] = IDX_W'(NUM_STATES - 1 - min_raw);
        e.pm[1]  = SM_W'(min_pm);
        e.idx[1] = IDX_W'(min_raw);
        e.pm[2]  = SM_W'(max_pm);
        e.idx[2] = IDX_W'(NUM_STATES - 1 - max_raw);
        q.push_back(e);
    endtask

    // Entered and left at posedge+1; returns once the beat has been accepted.
    task automatic send_beat(input int b, input logic last);
        int n;
        for (int k = 0; k < LANES; k++) in_pm[k*SM_W +: SM_W] = vec[b*LANES + k];
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready[0]) break;
            n++;
            if (n > 100) break;
        end
        if (n > 100) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout: beat %0d never accepted", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_step();
        send_beat(0, 1'b0);
        send_beat(1, 1'b1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && (q.size() != 0 || out_valid[0]); n++) @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t            e;
        logic            stalled;
        logic [SM_W-1:0] hpm [ND];
        logic [IDX_W-1:0] hidx [ND];
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    for (int d = 0; d < ND; d++) begin
                        chk($sformatf("hold_valid[%0d]", d), out_valid[d], 1);
                        chk($sformatf("hold_pm[%0d]", d), out_pm[d], hpm[d]);
                        chk($sformatf("hold_idx[%0d]", d), out_idx[d], hidx[d]);
                    end
                end
                stalled = 1'b0;
                if (out_valid[0]) begin
                    for (int d = 1; d < ND; d++) chk($sformatf("valid_align[%0d]", d),
                                                     out_valid[d], 1);
                    if (!out_ready) begin
                        chk("stall_in_ready", in_ready[0], 0);
                        stalled = 1'b1;
                        for (int d = 0; d < ND; d++) begin
                            hpm[d]  = out_pm[d];
                            hidx[d] = out_idx[d];
                        end
                    end else if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: pm %0d idx %0d with empty queue",
                                 out_pm[0], out_idx[0]);
                    end else begin
                        e = q.pop_front();
                        for (int d = 0; d < ND; d++) begin
                            chk($sformatf("out_pm[%0d]", d), out_pm[d], e.pm[d]);
                            chk($sformatf("out_idx[%0d]", d), out_idx[d], e.idx[d]);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_pm     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), out_valid[d], 0);
            chk($sformatf("rst_out_pm[%0d]", d), out_pm[d], 0);
            chk($sformatf("rst_out_idx[%0d]", d), out_idx[d], 0);
            chk($sformatf("rst_in_ready[%0d]", d), in_ready[d], 1);
            chk($sformatf("rst_err_seq[%0d]", d), err_seq[d], 0);
        end
        @(posedge clk);
        #1;

        // raw 37 = 12 among 100s, plus latency from the accepted last beat
        set_vec(100, 37, 12, -1, 0);
        push_exp(12, 37, 100, 0);
        send_step();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid[0] && n < 20);
        chk("latency", n, LAT);
        @(posedge clk);
        #1;

        // 2s everywhere: 250 beats 2 modulo 256 in min mode; 4 beats 2 in max mode
        set_vec(2, 3, 250, 40, 4);
        push_exp(250, 3, 4, 40);
        send_step();
        // 200s: 200 beats both 250 and 4 in min mode; 4 beats 250 and 200 in max mode
        set_vec(200, 3, 250, 40, 4);
        push_exp(200, 0, 4, 40);
        send_step();
        // tie between raw 10 and raw 50
        set_vec(90, 10, 7, 50, 7);
        push_exp(7, 10, 90, 0);
        send_step();
        // 180 among 100s
        set_vec(100, 45, 180, -1, 0);
        push_exp(100, 0, 180, 45);
        send_step();
        wait_drain();
        for (int d = 0; d < ND; d++) chk($sformatf("err_clean[%0d]", d), err_seq[d], 0);

        // Backpressure: consumer stalls for 5 cycles once the first result appears
        out_ready = 1'b0;
        push_exp(12, 37, 100, 0);
        push_exp(7, 10, 90, 0);
        push_exp(100, 0, 180, 45);
        fork
            begin
                set_vec(100, 37, 12, -1, 0);
                send_step();
                repeat (3) @(posedge clk);
                #1;
                set_vec(90, 10, 7, 50, 7);
                send_step();
                set_vec(100, 45, 180, -1, 0);
                send_step();
            end
            begin
                int m;
                m = 0;
                while (!out_valid[0] && m < 50) begin
                    @(negedge clk);
                    m++;
                end
                chk("bp_result_seen", out_valid[0], 1);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Sequence errors: early last, then a full count without last
        set_vec(90, 10, 7, 50, 7);
        push_exp(7, 10, 90, 0);
        send_beat(0, 1'b1);
        set_vec(100, 45, 180, -1, 0);
        push_exp(100, 0, 180, 45);
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        set_vec(2, 3, 250, 40, 4);
        push_exp(250, 3, 4, 40);
        send_step();
        wait_drain();
        for (int d = 0; d < ND; d++) chk($sformatf("err_sticky[%0d]", d), err_seq[d], 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) chk($sformatf("err_cleared[%0d]", d), err_seq[d], 0);
        @(posedge clk);
        #1;

        // Reset mid-step discards beat 0; the next step starts from count 0
        set_vec(100, 37, 12, -1, 0);
        send_beat(0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_vec(90, 10, 7, 50, 7);
        push_exp(7, 10, 90, 0);
        send_step();
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
